jts16_cen_meter: RTL and testbench
==================================

Name: jts16_cen_meter

Overview:
- Measures a clock-enable stream produced by the S16 fractional clock-enable generators (cpu, fm, snd, pcm).
- Counts pulses per fixed window and tracks the min/max gap between pulses.
- Flags out-of-range gaps and stalls.
- Used in simulation harnesses and as an optional on-chip debug monitor for the S16 core timing.

Parameters:
- WIN, 65536: window length in clk cycles (>=2).
- CW, 17: width of the pulse count output; must hold WIN.
- GW, 8: gap counter width; the gap counter saturates at 2^GW-1.
- GAP_MIN, 5: smallest legal gap in clk cycles.
- GAP_MAX, 6: largest legal gap in clk cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- cen  in  1  clock-enable under test; one clk cycle per pulse.
- clr  in  1  clears sticky err; other state unaffected.
- cnt  out CW  cen pulses counted in the last completed window.
- min_gap  out GW  smallest gap seen in the last completed window.
- max_gap  out GW  largest gap seen in the last completed window.
- valid  out 1  one-cycle strobe; cnt, min_gap and max_gap updated this cycle.
- err  out 1  sticky; a gap was outside [GAP_MIN,GAP_MAX], or a stall occurred.
- stall  out 1  high while no cen has arrived for 2^GW-1 cycles.

Behaviour:
- Reset values:
  - cnt=0, min_gap=all ones, max_gap=0, valid=0, err=0, stall=0.
  - Window counter=0, gap counter=0, armed=0.
- Gap definition: number of clk cycles from one cen cycle to the next. Back-to-back cen gives gap 1.
- armed flag:
  - Set on the first cen after rst.
  - A gap is measured only when cen arrives with armed=1. The first pulse after reset yields no gap.
- Gap counter:
  - Loads 1 on a cen cycle; otherwise increments, saturating at 2^GW-1.
  - Measured gap = counter value on the cen cycle.
  - A saturated gap is recorded as 2^GW-1.
- Accumulators:
  - pcnt += cen.
  - acc_min = min(acc_min, gap); acc_max = max(acc_max, gap), both on measured gaps only.
- Window counter:
  - Counts 0..WIN-1, then wraps to 0.
  - On the cycle where it equals WIN-1:
    - Outputs are latched one cycle later, together with valid=1 for that single cycle.
    - The latched values include any cen or gap occurring on the WIN-1 cycle itself.
    - Accumulators restart for the next window at pcnt=0, acc_min=all ones, acc_max=0.
  - Window-end and a cen on the same cycle: the pulse belongs to the closing window, never the next one.
- Gaps spanning a window boundary are measured; they are attributed to the window in which the closing cen falls.
- Windows with no measured gap report min_gap=all ones and max_gap=0.
- err:
  - Set on a measured gap < GAP_MIN or > GAP_MAX.
  - Set when the gap counter reaches saturation while armed.
  - Cleared by clr only if no set condition occurs in the same cycle; set wins.
- stall:
  - Asserts the cycle the armed gap counter reaches 2^GW-1.
  - Deasserts on the next cen.
- valid latency: exactly WIN cycles after reset release for the first strobe, then every WIN cycles.
- Reset mid-window: all state returns to reset values, including armed=0; the next window starts at counter 0.
- pcnt saturates at 2^CW-1 and never wraps.

Decomposition:
- Shared package jts16_pkg holds the per-stream legal gap limits as constants:
  - CPU 5/6
  - FM 12/13
  - SND 10/11
  - PCM (S16A) 8/9
- One natural sub-module, jts16_gap_tracker: armed flag, saturating gap counter, min/max/err/stall logic. The top holds the window counter, pulse counter and output latches.

Test Plan:
- WIN=100; cen every 5 cycles, starting cycle 0 after reset → valid at cycle 100; cnt=20, min_gap=5, max_gap=5, err=0.
- WIN=100; gap pattern 5,5,5,5,6 repeating → cnt=19 or 20 depending on phase; min_gap=5, max_gap=6, err=0 across 10 windows.
- A single gap of 4 inserted → err=1 from the cycle after that cen. err stays high through window ends; a clr pulse drops it to 0.
- GW=4; cen held low for 20 cycles after one pulse → stall=1 at 15 cycles after the pulse, err=1. Next cen: stall=0; the window reports max_gap=15.
- cen asserted exactly on window cycle WIN-1 → counted in the closing window's cnt; the following window's first strobe excludes it.
- rst asserted at window cycle 50 with err=1 → all outputs return to reset values. The first following cen yields no gap, and the next valid comes WIN cycles after rst release.

Source files
------------

// File: rtl/jts16_pkg.sv
// Shared constants for the S16 clock-enable monitors: legal gap windows of
// each fractional clock-enable stream, in clk cycles.
package jts16_pkg;

  typedef enum logic [1:0] {
    STREAM_CPU = 2'd0,
    STREAM_FM  = 2'd1,
    STREAM_SND = 2'd2,
    STREAM_PCM = 2'd3
  } stream_e;

  localparam int CPU_GAP_MIN = 5;
  localparam int CPU_GAP_MAX = 6;
  localparam int FM_GAP_MIN  = 12;
  localparam int FM_GAP_MAX  = 13;
  localparam int SND_GAP_MIN = 10;
  localparam int SND_GAP_MAX = 11;
  localparam int PCM_GAP_MIN = 8;   // S16A PCM
  localparam int PCM_GAP_MAX = 9;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
  } gap_lim_t;

  function automatic gap_lim_t stream_limits(input stream_e s);
    gap_lim_t l;
    case (s)
      STREAM_CPU: l = '{lo: 8'(CPU_GAP_MIN), hi: 8'(CPU_GAP_MAX)};
      STREAM_FM:  l = '{lo: 8'(FM_GAP_MIN),  hi: 8'(FM_GAP_MAX)};
      STREAM_SND: l = '{lo: 8'(SND_GAP_MIN), hi: 8'(SND_GAP_MAX)};
      STREAM_PCM: l = '{lo: 8'(PCM_GAP_MIN), hi: 8'(PCM_GAP_MAX)};
      default:    l = '{lo: 8'(CPU_GAP_MIN), hi: 8'(CPU_GAP_MAX)};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/jts16_gap_tracker.sv
// Gap side of the cen meter: saturating gap counter, per-window min/max of
// measured gaps, and the sticky range error / stall flags.
module jts16_gap_tracker
  import jts16_pkg::*;
#(
  parameter int GW      = 8,
  parameter int GAP_MIN = CPU_GAP_MIN,
  parameter int GAP_MAX = CPU_GAP_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          clr,
  input  logic          win_end,
  output logic [GW-1:0] win_min,
  output logic [GW-1:0] win_max,
  output logic          err,
  output logic          stall
);

  localparam logic [GW-1:0] ONES = {GW{1'b1}};
  localparam logic [GW-1:0] GMIN = GW'(GAP_MIN);
  localparam logic [GW-1:0] GMAX = GW'(GAP_MAX);

  logic          armed_r;
  logic [GW-1:0] gcnt_r;
  logic [GW-1:0] acc_min_r;
  logic [GW-1:0] acc_max_r;
  logic          err_r;
  logic          stall_r;

  logic          meas_s;
  logic          hit_sat_s;
  logic          bad_gap_s;
  logic [GW-1:0] gcnt_nxt_s;
  logic [GW-1:0] min_s;
  logic [GW-1:0] max_s;

  // Gap measurement and closing min/max including this cycle's gap
  always_comb begin
    meas_s    = armed_r & cen;
    hit_sat_s = armed_r & ~cen & (gcnt_r == ONES - 1'b1);
    bad_gap_s = meas_s & ((gcnt_r < GMIN) | (gcnt_r > GMAX));
    if (cen) begin
      gcnt_nxt_s = {{(GW-1){1'b0}}, 1'b1};
    end else if (gcnt_r == ONES) begin
      gcnt_nxt_s = gcnt_r;
    end else begin
      gcnt_nxt_s = gcnt_r + 1'b1;
    end
    if (meas_s && (gcnt_r < acc_min_r)) begin
      min_s = gcnt_r;
    end else begin
      min_s = acc_min_r;
    end
    if (meas_s && (gcnt_r > acc_max_r)) begin
      max_s = gcnt_r;
    end else begin
      max_s = acc_max_r;
    end
  end

  // Gap state; accumulators restart when the window closes, set beats clr
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_r   <= 1'b0;
      gcnt_r    <= '0;
      acc_min_r <= ONES;
      acc_max_r <= '0;
      err_r     <= 1'b0;
      stall_r   <= 1'b0;
    end else begin
      armed_r   <= armed_r | cen;
      gcnt_r    <= gcnt_nxt_s;
      acc_min_r <= win_end ? ONES : min_s;
      acc_max_r <= win_end ? '0 : max_s;
      if (bad_gap_s || hit_sat_s) begin
        err_r <= 1'b1;
      end else if (clr) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
      if (cen) begin
        stall_r <= 1'b0;
      end else if (hit_sat_s) begin
        stall_r <= 1'b1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end

  assign win_min = min_s;
  assign win_max = max_s;
  assign err     = err_r;
  assign stall   = stall_r;

endmodule

// File: rtl/jts16_cen_meter.sv
// Clock-enable meter: counts cen pulses per WIN-cycle window and reports the
// min/max pulse gap of each completed window with a one-cycle valid strobe.
module jts16_cen_meter
  import jts16_pkg::*;
#(
  parameter int WIN     = 65536,
  parameter int CW      = 17,
  parameter int GW      = 8,
  parameter int GAP_MIN = CPU_GAP_MIN,
  parameter int GAP_MAX = CPU_GAP_MAX
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic [GW-1:0] min_gap,
  output logic [GW-1:0] max_gap,
  output logic          valid,
  output logic          err,
  output logic          stall
);

  localparam int            WW    = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WW-1:0] WLAST = WW'(WIN - 1);

  logic [WW-1:0] wcnt_r;
  logic [CW-1:0] pcnt_r;
  logic [CW-1:0] cnt_r;
  logic [GW-1:0] min_gap_r;
  logic [GW-1:0] max_gap_r;
  logic          valid_r;

  logic          win_end_s;
  logic [CW-1:0] pcnt_nxt_s;
  logic [GW-1:0] win_min_s;
  logic [GW-1:0] win_max_s;

  jts16_gap_tracker #(
    .GW      (GW),
    .GAP_MIN (GAP_MIN),
    .GAP_MAX (GAP_MAX)
  ) u_gap (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .clr     (clr),
    .win_end (win_end_s),
    .win_min (win_min_s),
    .win_max (win_max_s),
    .err     (err),
    .stall   (stall)
  );

  // Window end detection and saturating pulse count including this cycle
  always_comb begin
    win_end_s = (wcnt_r == WLAST);
    if (cen && (pcnt_r != {CW{1'b1}})) begin
      pcnt_nxt_s = pcnt_r + 1'b1;
    end else begin
      pcnt_nxt_s = pcnt_r;
    end
  end

  // Window counter, pulse accumulator and output latches
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_r    <= '0;
      pcnt_r    <= '0;
      cnt_r     <= '0;
      min_gap_r <= {GW{1'b1}};
      max_gap_r <= '0;
      valid_r   <= 1'b0;
    end else begin
      valid_r <= win_end_s;
      if (win_end_s) begin
        wcnt_r    <= '0;
        pcnt_r    <= '0;
        cnt_r     <= pcnt_nxt_s;
        min_gap_r <= win_min_s;
        max_gap_r <= win_max_s;
      end else begin
        wcnt_r    <= wcnt_r + 1'b1;
        pcnt_r    <= pcnt_nxt_s;
        cnt_r     <= cnt_r;
        min_gap_r <= min_gap_r;
        max_gap_r <= max_gap_r;
      end
    end
  end

  assign cnt     = cnt_r;
  assign min_gap = min_gap_r;
  assign max_gap = max_gap_r;
  assign valid   = valid_r;

endmodule

// File: tb/tb_jts16_cen_meter.sv
// Directed bench for jts16_cen_meter (WIN=100, GW=4): a cycle-indexed model
// pushes expected window results to a queue, popped when valid strobes.
module tb_jts16_cen_meter;

  localparam int WIN  = 100;
  localparam int CW   = 17;
  localparam int GW   = 4;
  localparam int GMIN = 5;
  localparam int GMAX = 6;
  localparam int GSAT = 15;

  typedef struct {
    int c;
    int mn;
    int mx;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          clr = 1'b0;
  logic [CW-1:0] cnt;
  logic [GW-1:0] min_gap;
  logic [GW-1:0] max_gap;
  logic          valid;
  logic          err;
  logic          stall;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t sbq[$];

  int   m_last  = 0;
  bit   m_armed = 1'b0;
  bit   m_err   = 1'b0;
  int   m_pcnt  = 0;
  int   m_min   = GSAT;
  int   m_max   = 0;

  jts16_cen_meter #(
    .WIN     (WIN),
    .CW      (CW),
    .GW      (GW),
    .GAP_MIN (GMIN),
    .GAP_MAX (GMAX)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .clr     (clr),
    .cnt     (cnt),
    .min_gap (min_gap),
    .max_gap (max_gap),
    .valid   (valid),
    .err     (err),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cen = 1'b0;
    clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst     = 1'b0;
    cyc     = 0;
    m_last  = 0;
    m_armed = 1'b0;
    m_err   = 1'b0;
    m_pcnt  = 0;
    m_min   = GSAT;
    m_max   = 0;
    chk("rst_cnt", cnt, 0);
    chk("rst_min_gap", min_gap, GSAT);
    chk("rst_max_gap", max_gap, 0);
    chk("rst_valid", valid, 0);
    chk("rst_err", err, 0);
    chk("rst_stall", stall, 0);
  endtask

  // one clk cycle: check outputs of this cycle, drive inputs, update model
  task automatic tick(input logic c, input logic cl);
    int   g;
    exp_t e;
    if (m_armed && (cyc - m_last == GSAT)) m_err = 1'b1;
    chk("stall", stall, (m_armed && (cyc - m_last >= GSAT)) ? 1 : 0);
    chk("err", err, m_err ? 1 : 0);
    if (cyc > 0 && (cyc % WIN) == 0) begin
      chk("valid", valid, 1);
      chk("sb_nonempty", (sbq.size() > 0) ? 1 : 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("cnt", cnt, e.c);
        chk("min_gap", min_gap, e.mn);
        chk("max_gap", max_gap, e.mx);
      end
    end else begin
      chk("valid", valid, 0);
    end
    cen = c;
    clr = cl;
    if (cl) m_err = 1'b0;
    if (c) begin
      m_pcnt++;
      if (m_armed) begin
        g = cyc - m_last;
        if (g > GSAT) g = GSAT;
        if (g < m_min) m_min = g;
        if (g > m_max) m_max = g;
        if (g < GMIN || g > GMAX) m_err = 1'b1;
      end
      m_armed = 1'b1;
      m_last  = cyc;
    end
    if ((cyc % WIN) == WIN - 1) begin
      sbq.push_back('{c: m_pcnt, mn: m_min, mx: m_max});
      m_pcnt = 0;
      m_min  = GSAT;
      m_max  = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // g-1 idle cycles then a cen cycle: gap g from the previous pulse
  task automatic pulse_after(input int g);
    for (int i = 0; i < g - 1; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  initial begin
    do_reset();

    // steady gap 5 from cycle 0: first window 20 pulses, min=max=5
    tick(1'b1, 1'b0);
    for (int i = 0; i < 39; i++) pulse_after(5);

    // 5,5,5,5,6 pattern over ten windows
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 4; k++) pulse_after(5);
      pulse_after(6);
    end

    // short gap sets err; it survives window ends until clr
    pulse_after(4);
    for (int i = 0; i < 25; i++) pulse_after(5);
    tick(1'b0, 1'b1);
    pulse_after(4);
    chk("err_after_clr", err, 0);

    // 20 idle cycles: stall after 15, gap reported as saturated 15
    pulse_after(21);
    chk("stall_cleared", stall, 0);
    for (int i = 0; i < 30; i++) pulse_after(5);
    tick(1'b0, 1'b1);
    pulse_after(4);

    // pulse on the last window cycle belongs to the closing window
    while ((cyc % WIN) != WIN - 1) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 25; i++) pulse_after(5);
    tick(1'b0, 1'b1);
    pulse_after(4);

    // reset at window cycle 50 while err is set
    pulse_after(4);
    while ((cyc % WIN) != 50) tick(1'b0, 1'b0);
    chk("err_before_rst", err, 1);
    sbq.delete();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    for (int i = 0; i < 45; i++) pulse_after(5);

    for (int i = 0; i < 2 * WIN && sbq.size() > 0; i++) tick(1'b0, 1'b0);
    chk("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
